// File: rtl/button_event_pkg.sv
// button_event_pkg: shared types, board-clock defaults and counter sizing for the button event bank.
package button_event_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 1023;
  localparam int DEF_LONG_CYCLES = 2**24;
  localparam int DEF_REPEAT_CYCLES = 2**22;
  typedef struct packed {
    logic state;
    logic pressed;
    logic released;
    logic long_hold;
    logic rpt;
  } btn_event_t;
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/button_event_channel.sv
// button_event_channel: one button - sync, debounce, press/release/long pulses, auto-repeat.
// Auto-repeat is built only when BUTTON_EVENT_AUTOREPEAT_EN is defined.
module button_event_channel
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Button,
  output btn_event_t o_Event
);
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  logic [1:0] sync_q;
  logic [DW-1:0] dc_q, dc_d;
  logic [HW-1:0] hc_q, hc_d;
  btn_event_t ev_q, ev_d;
  logic s, mismatch, accept, held;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  logic [RW-1:0] rc_q, rc_d;
  logic rep_on, rep_hit;
`endif
  always_comb begin
    s = sync_q[1];
    mismatch = s != ev_q.state;
    accept = mismatch && dc_q == DW'(DEBOUNCE_CYCLES - 1);
    held = ev_q.state && !accept;
    dc_d = (mismatch && !accept) ? dc_q + DW'(1) : '0;
    hc_d = !held ? '0 : (hc_q == HW'(LONG_CYCLES)) ? hc_q : hc_q + HW'(1);
    ev_d.state = accept ? s : ev_q.state;
    ev_d.pressed = accept && s;
    ev_d.released = accept && !s;
    ev_d.long_hold = held && hc_q == HW'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    rep_on = held && hc_q == HW'(LONG_CYCLES);
    rep_hit = rep_on && rc_q == RW'(REPEAT_CYCLES - 1);
    rc_d = (rep_on && !rep_hit) ? rc_q + RW'(1) : '0;
    ev_d.rpt = rep_hit;
`else
    ev_d.rpt = REPEAT_CYCLES < 0;
`endif
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      sync_q <= '0;
      dc_q <= '0;
      hc_q <= '0;
      ev_q <= '0;
    end else begin
      sync_q <= {sync_q[0], i_Button};
      dc_q <= dc_d;
      hc_q <= hc_d;
      ev_q <= ev_d;
    end
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) rc_q <= '0;
    else rc_q <= rc_d;
`endif
  assign o_Event = ev_q;
endmodule

// File: rtl/button_event_bank.sv
// button_event_bank: N independent debounced push-button channels with event pulses.
// o_Repeat is live only when BUTTON_EVENT_AUTOREPEAT_EN is defined.
module button_event_bank
  import button_event_pkg::*;
#(
  parameter int N_CHANNELS = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic [N_CHANNELS-1:0] i_Buttons,
  output logic [N_CHANNELS-1:0] o_State,
  output logic [N_CHANNELS-1:0] o_Pressed,
  output logic [N_CHANNELS-1:0] o_Released,
  output logic [N_CHANNELS-1:0] o_Long,
  output logic [N_CHANNELS-1:0] o_Repeat
);
  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    btn_event_t ev;
    button_event_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .i_Clock(i_Clock),
      .i_Reset_n(i_Reset_n),
      .i_Button(i_Buttons[c]),
      .o_Event(ev)
    );
    assign o_State[c] = ev.state;
    assign o_Pressed[c] = ev.pressed;
    assign o_Released[c] = ev.released;
    assign o_Long[c] = ev.long_hold;
    assign o_Repeat[c] = ev.rpt;
  end
endmodule
